// File: rtl/alu_pkg.sv
// Shared ALU definitions: instruction field positions, Cond encodings, flag
// bit indices and the op_code values understood by simple_ALU.
package alu_pkg;

  localparam int COND_HI = 31;
  localparam int COND_LO = 28;
  localparam int OP_HI   = 27;
  localparam int OP_LO   = 24;
  localparam int S_BIT   = 23;
  localparam int SR_HI   = 22;
  localparam int SR_LO   = 20;
  localparam int RS1_HI  = 19;
  localparam int RS1_LO  = 16;
  localparam int RS2_HI  = 15;
  localparam int RS2_LO  = 12;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_SHF = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition check of a 4-bit Cond code against {N,Z,C,V};
// unlisted encodings (0, 9-15) always pass.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass =  flags[FLAG_Z];
      COND_NE: pass = !flags[FLAG_Z];
      COND_CS: pass =  flags[FLAG_C];
      COND_CC: pass = !flags[FLAG_C];
      COND_MI: pass =  flags[FLAG_N];
      COND_PL: pass = !flags[FLAG_N];
      COND_VS: pass =  flags[FLAG_V];
      COND_VC: pass = !flags[FLAG_V];
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding simple_ALU: decodes instructions, registers one packet,
// owns the status flags. Optional conditional squash: ALU_ISSUE_COND_SQUASH_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic [3:0]        rs1_addr,
  output logic [3:0]        rs2_addr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic [3:0]        op_code,
  output logic [3:0]        Cond,
  output logic              S,
  output logic [2:0]        SR_Control,
  output logic [15:0]       Imm,
  output logic [3:0]        flags,
  input  logic [3:0]        FLG,
  output logic [CNT_W-1:0]  issued_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d;
  logic [3:0]        op_q, op_d, cond_q, cond_d;
  logic              s_q, s_d;
  logic [2:0]        sr_q, sr_d;
  logic [15:0]       imm_q, imm_d;
  logic [3:0]        flags_q, flags_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic consume, accept, stall, cond_ok;

  assign rs1_addr = instr[RS1_HI:RS1_LO];
  assign rs2_addr = instr[RS2_HI:RS2_LO];

  always_comb begin
    consume = out_valid_q && out_ready;
    flags_d = (consume && s_q) ? FLG : flags_q;
    cnt_d   = consume ? cnt_q + CNT_W'(1) : cnt_q;
  end

`ifdef ALU_ISSUE_COND_SQUASH_EN
  // Evaluate against the flags being written this edge so a flag-setting op
  // followed by a dependent conditional op streams without a bubble.
  alu_cond_eval u_cond_eval (
    .cond  (instr[COND_HI:COND_LO]),
    .flags (flags_d),
    .pass  (cond_ok)
  );

  assign stall = (instr[COND_HI:COND_LO] != COND_AL) && out_valid_q && s_q && !out_ready;
`else
  assign cond_ok = 1'b1;
  assign stall   = 1'b0;
`endif

  assign in_ready = (!out_valid_q || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    op_d        = op_q;
    cond_d      = cond_q;
    s_d         = s_q;
    sr_d        = sr_q;
    imm_d       = imm_q;
    if (consume) begin
      out_valid_d = 1'b0;
    end
    // A squashed accept leaves the packet registers untouched and invalid.
    if (accept) begin
      out_valid_d = cond_ok;
      if (cond_ok) begin
        r1_d   = rs1_data;
        r2_d   = rs2_data;
        op_d   = instr[OP_HI:OP_LO];
        cond_d = instr[COND_HI:COND_LO];
        s_d    = instr[S_BIT];
        sr_d   = instr[SR_HI:SR_LO];
        imm_d  = instr[IMM_HI:IMM_LO];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      r1_q        <= '0;
      r2_q        <= '0;
      op_q        <= '0;
      cond_q      <= '0;
      s_q         <= 1'b0;
      sr_q        <= '0;
      imm_q       <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      op_q        <= op_d;
      cond_q      <= cond_d;
      s_q         <= s_d;
      sr_q        <= sr_d;
      imm_q       <= imm_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign R1         = r1_q;
  assign R2         = r2_q;
  assign op_code    = op_q;
  assign Cond       = cond_q;
  assign S          = s_q;
  assign SR_Control = sr_q;
  assign Imm        = imm_q;
  assign flags      = flags_q;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage (CNT_W=4 to reach the counter wrap);
// inputs change on the falling edge, outputs are checked there too.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [3:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] R1, R2;
  logic [3:0]  op_code, Cond;
  logic        S;
  logic [2:0]  SR_Control;
  logic [15:0] Imm;
  logic [3:0]  flags;
  logic [3:0]  FLG = '0;
  logic [3:0]  issued_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid),
    .out_ready(out_ready), .R1(R1), .R2(R2), .op_code(op_code), .Cond(Cond),
    .S(S), .SR_Control(SR_Control), .Imm(Imm), .flags(flags), .FLG(FLG),
    .issued_cnt(issued_cnt)
  );

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op,
                                     input logic s, input logic [2:0] sr,
                                     input logic [3:0] rs1, input logic [15:0] imm);
    return {c, op, s, sr, rs1, imm};
  endfunction

  task automatic drive(input logic v, input logic [31:0] i,
                       input logic [31:0] d1, input logic [31:0] d2);
    in_valid = v;
    instr    = i;
    rs1_data = d1;
    rs2_data = d2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    checks++;
    if (issued_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", issued_cnt); end
    checks++;
    if ({R1, R2, op_code, Cond, S, SR_Control, Imm} !== '0) begin
      errors++; $display("FAIL reset_packet: R1=%h R2=%h op=%h imm=%h want zeros", R1, R2, op_code, Imm);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    $display("reset: out_valid=%b flags=%b cnt=%0d", out_valid, flags, issued_cnt);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    drive(1'b0, mk(4'hA, 4'h5, 1'b1, 3'b101, 4'h9, 16'hC3F0), 32'd0, 32'd0);
    #1;
    checks++;
    if (rs1_addr !== 4'h9) begin errors++; $display("FAIL decode_rs1: got %h want 9", rs1_addr); end
    checks++;
    if (rs2_addr !== 4'hC) begin errors++; $display("FAIL decode_rs2: got %h want c", rs2_addr); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_accept: out_valid=%b want 0", out_valid); end
    $display("decode: rs1=%h rs2=%h", rs1_addr, rs2_addr);
  endtask

  task automatic test_stream();
    logic [3:0]  ops [3] = '{4'd3, 4'd1, 4'd3};
    logic [31:0] av  [3] = '{32'd5, 32'd5, 32'd3};
    logic [31:0] bv  [3] = '{32'd3, 32'd2, 32'd2};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, mk(4'h0, ops[i], 1'b0, 3'b000, 4'h1, 16'h2000), av[i], bv[i]);
      else drive(1'b0, 32'd0, 32'd0, 32'd0);
      if (i > 0) begin
        checks++;
        if ({out_valid, op_code, R1, R2} !== {1'b1, ops[i-1], av[i-1], bv[i-1]}) begin
          errors++;
          $display("FAIL stream_pkt%0d: v=%b op=%0d R1=%0d R2=%0d want v=1 op=%0d R1=%0d R2=%0d",
                   i-1, out_valid, op_code, R1, R2, ops[i-1], av[i-1], bv[i-1]);
        end
        $display("stream: pkt%0d op=%0d R1=%0d R2=%0d", i-1, op_code, R1, R2);
      end
      if (i < 3) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); end
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, issued_cnt, flags} !== {1'b0, 4'd3, 4'b0000}) begin
      errors++; $display("FAIL stream_end: v=%b cnt=%0d flags=%b want v=0 cnt=3 flags=0000", out_valid, issued_cnt, flags);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, mk(4'h0, 4'd4, 1'b0, 3'b010, 4'h2, 16'h1234), 32'h11, 32'h22);
    @(negedge clk);
    drive(1'b1, mk(4'h0, 4'd2, 1'b0, 3'b000, 4'h3, 16'h5678), 32'h33, 32'h44);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({out_valid, op_code, R1, R2, Imm, SR_Control} !== {1'b1, 4'd4, 32'h11, 32'h22, 16'h1234, 3'b010}) begin
        errors++; $display("FAIL bp_hold%0d: v=%b op=%0d R1=%h R2=%h imm=%h want 1/4/11/22/1234", k, out_valid, op_code, R1, R2, Imm);
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); end
      $display("backpressure: cycle %0d held op=%0d", k, op_code);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
    checks++;
    if ({out_valid, op_code, R1, R2, issued_cnt} !== {1'b1, 4'd2, 32'h33, 32'h44, 4'd4}) begin
      errors++; $display("FAIL bp_next: v=%b op=%0d R1=%h cnt=%0d want 1/2/33/4", out_valid, op_code, R1, issued_cnt);
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if ({out_valid, issued_cnt} !== {1'b0, 4'd5}) begin
      errors++; $display("FAIL bp_drain: v=%b cnt=%0d want 0/5", out_valid, issued_cnt);
    end
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    FLG = 4'b0100;
    drive(1'b1, mk(4'h0, 4'd4, 1'b1, 3'b000, 4'h1, 16'h0000), 32'd7, 32'd7);
    @(negedge clk);
    checks++;
    if ({out_valid, S, flags} !== {1'b1, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL flag_pre: v=%b S=%b flags=%b want 1/1/0000", out_valid, S, flags);
    end
    drive(1'b1, mk(4'h0, 4'd3, 1'b0, 3'b000, 4'h1, 16'h0000), 32'd1, 32'd1);
    @(negedge clk);
    checks++;
    if (flags !== 4'b0100) begin errors++; $display("FAIL flag_set: got %b want 0100", flags); end
    $display("flags: after S=1 consume flags=%b", flags);
    FLG = 4'b1111;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if ({flags, issued_cnt} !== {4'b0100, 4'd7}) begin
      errors++; $display("FAIL flag_s0: flags=%b cnt=%0d want 0100/7", flags, issued_cnt);
    end
    @(negedge clk);
    checks++;
    if (flags !== 4'b0100) begin errors++; $display("FAIL flag_empty: got %b want 0100", flags); end
    $display("flags: after S=0 consume flags=%b", flags);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, mk(4'h0, 4'd6, 1'b1, 3'b001, 4'h4, 16'h00FF), 32'h77, 32'h88);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: out_valid=%b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, flags, issued_cnt} !== {1'b0, 4'b0000, 4'd0}) begin
      errors++; $display("FAIL areset: v=%b flags=%b cnt=%0d want 0/0000/0", out_valid, flags, issued_cnt);
    end
    checks++;
    if ({R1, op_code, S, Imm} !== '0) begin
      errors++; $display("FAIL areset_pkt: R1=%h op=%0d S=%b imm=%h want zeros", R1, op_code, S, Imm);
    end
    $display("async reset: out_valid=%b flags=%b cnt=%0d", out_valid, flags, issued_cnt);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    FLG = 4'b0100;
  endtask

`ifdef ALU_ISSUE_COND_SQUASH_EN
  task automatic test_squash();
    out_ready = 1'b1;
    drive(1'b1, mk(4'h1, 4'd5, 1'b0, 3'b000, 4'h1, 16'h0000), 32'd9, 32'd9);
    @(negedge clk);
    checks++;
    if ({out_valid, issued_cnt} !== {1'b0, 4'd0}) begin
      errors++; $display("FAIL squash: v=%b cnt=%0d want 0/0", out_valid, issued_cnt);
    end
    out_ready = 1'b0;
    drive(1'b1, mk(4'h0, 4'd3, 1'b1, 3'b000, 4'h1, 16'h0000), 32'd1, 32'd1);
    @(negedge clk);
    drive(1'b1, mk(4'h1, 4'd7, 1'b0, 3'b000, 4'h1, 16'h0000), 32'd8, 32'd8);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL squash_stall: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    checks++;
    if ({out_valid, op_code, S} !== {1'b1, 4'd3, 1'b1}) begin
      errors++; $display("FAIL squash_hold: v=%b op=%0d S=%b want 1/3/1", out_valid, op_code, S);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL squash_release: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    checks++;
    if ({out_valid, op_code, flags, issued_cnt} !== {1'b1, 4'd7, 4'b0100, 4'd1}) begin
      errors++; $display("FAIL squash_cond_pass: v=%b op=%0d flags=%b cnt=%0d want 1/7/0100/1", out_valid, op_code, flags, issued_cnt);
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (issued_cnt !== 4'd2) begin errors++; $display("FAIL squash_cnt: got %0d want 2", issued_cnt); end
    $display("squash: cnt=%0d flags=%b", issued_cnt, flags);
  endtask
`else
  task automatic test_cond_passthrough();
    out_ready = 1'b1;
    drive(1'b1, mk(4'h1, 4'd5, 1'b0, 3'b000, 4'h1, 16'h0000), 32'd9, 32'd9);
    @(negedge clk);
    checks++;
    if ({out_valid, Cond, op_code} !== {1'b1, 4'h1, 4'd5}) begin
      errors++; $display("FAIL cond_pass: v=%b cond=%h op=%0d want 1/1/5", out_valid, Cond, op_code);
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (issued_cnt !== 4'd1) begin errors++; $display("FAIL cond_cnt: got %0d want 1", issued_cnt); end
    $display("cond passthrough: cond=%h cnt=%0d", Cond, issued_cnt);
  endtask
`endif

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, mk(4'h0, 4'(i), 1'b0, 3'b000, 4'h1, 16'(i)), 32'(i), 32'(i + 1));
      @(negedge clk);
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if ({out_valid, issued_cnt} !== {1'b0, 4'd1}) begin
      errors++; $display("FAIL wrap: v=%b cnt=%0d want 0/1", out_valid, issued_cnt);
    end
    $display("wrap: 17 consumed, cnt=%0d", issued_cnt);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_stream();
    test_backpressure();
    test_flags();
    test_async_reset();
`ifdef ALU_ISSUE_COND_SQUASH_EN
    test_squash();
`else
    test_cond_passthrough();
`endif
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of simple_ALU.
- Accepts 32-bit instruction words over a valid/ready handshake, decodes them into the ALU control fields, and captures register-file operands.
- Presents one registered issue packet to the ALU over a valid/ready handshake.
- Owns the architectural 4-bit status register ("flags" input of the ALU), updated from the ALU FLG output when an issued op has S=1.

Parameters:
- DATA_W, 32, operand width (R1/R2).
- CNT_W, 16, width of the issued-op counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept an instruction this cycle
- instr  in  32  instruction word
- rs1_addr  out  4  register-file read address 1, = instr[19:16], combinational
- rs2_addr  out  4  register-file read address 2, = instr[15:12], combinational
- rs1_data  in  DATA_W  register-file read data 1, same cycle
- rs2_data  in  DATA_W  register-file read data 2, same cycle
- out_valid  out  1  issue packet valid to ALU
- out_ready  in  1  ALU/writeback consumes the packet this cycle
- R1  out  DATA_W  operand 1
- R2  out  DATA_W  operand 2
- op_code  out  4  instr[27:24]
- Cond  out  4  instr[31:28]
- S  out  1  instr[23], set-flags request
- SR_Control  out  3  instr[22:20]
- Imm  out  16  instr[15:0]
- flags  out  4  status register {N,Z,C,V}
- FLG  in  4  ALU flag result for the packet currently presented
- issued_cnt  out  CNT_W  count of packets consumed

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; R1, R2, op_code, Cond, S, SR_Control, Imm = 0.
  - flags=4'b0000; issued_cnt=0.
  - A packet in flight at reset is discarded.
- Field decode:
  - Pure slicing.
  - rs2_addr overlaps Imm[15:12]; the ALU selects register or immediate by op_code, and this stage passes both.
- Accept:
  - Occurs when in_valid && in_ready.
  - Output register loads decoded fields plus rs1_data/rs2_data; out_valid=1 next cycle.
  - Latency: 1 cycle from accept to presentation.
- in_ready = (!out_valid || out_ready) && !stall.
  - Full-throughput streaming is supported; simultaneous consume and accept in one cycle is allowed.
  - stall is 0 unless COND_SQUASH_EN is defined.
- Hold: while out_valid && !out_ready, all outputs stay stable.
- Consume:
  - Occurs when out_valid && out_ready.
  - issued_cnt increments and wraps from 2^CNT_W-1 to 0.
  - If S=1, flags <= FLG in the same edge; if S=0, flags are unchanged.
- Empty: with out_valid=0, flags and the packet registers hold their values. FLG is ignored.
- in_valid is low-active-safe: instr is don't-care when in_valid=0.

Optional Feature:
- Macro: ALU_ISSUE_COND_SQUASH_EN.
- Defined: instructions whose Cond fails against flags are accepted but squashed, never presented, and not counted.
  - Cond encoding:
    - 0 = always
    - 1 = EQ (Z)
    - 2 = NE (!Z)
    - 3 = CS (C)
    - 4 = CC (!C)
    - 5 = MI (N)
    - 6 = PL (!N)
    - 7 = VS (V)
    - 8 = VC (!V)
    - 9-15 = always
  - Hazard rule: stall=1 when Cond≠0 at the input and the output register holds an S=1 packet not consumed this cycle.
  - On the consume edge, evaluation uses the flags value being written (FLG), so back-to-back flag-set then conditional streams at full rate.
  - A squashed accept leaves out_valid=0 if the output register was consumed or empty.
- Undefined: Cond is passed through unevaluated and stall is tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - instruction field bit-position constants;
  - Cond encoding localparams;
  - flag bit indices N=3, Z=2, C=1, V=0;
  - op_code constants shared with simple_ALU.
- One natural sub-module: alu_cond_eval (combinational Cond × flags → pass), reusable by the branch unit.

Test Plan:
- Reset: rst_n low mid-stream with out_valid=1 → out_valid=0, flags=0000, issued_cnt=0 asynchronously, before the next clk edge.
- Streaming, out_ready=1:
  - Stimulus: three instrs (op_code 3, R1=5, R2=3, S=0), (op_code 1, 5, 2, S=0), (op_code 3, 3, 2, S=0).
  - Response: presented on consecutive cycles, each 1 cycle after accept; issued_cnt=3; flags unchanged.
- Backpressure: out_ready=0 for 4 cycles with packet held → outputs stable, in_ready=0; release → packet consumed and next accepted the same cycle.
- Flag update:
  - Issue S=1 with FLG=4'b0100 at consume → flags=0100 the next cycle.
  - Then issue S=0 with FLG=1111 → flags stay 0100.
- Counter wrap: with CNT_W=4, consume 17 packets → issued_cnt=1.
- ALU_ISSUE_COND_SQUASH_EN:
  - Setup: flags=0000; issue Cond=1 (EQ) → squashed, out_valid stays 0, count unchanged.
  - Stimulus: S=1 op (FLG=0100 at consume) followed immediately by Cond=1.
  - Response: second op stalls only while the S op is unconsumed, then is presented.
